// File: rtl/updown_mod_counter.sv
// Up/down event/timer counter with programmable modulo limit, parallel load,
// wrap or saturate behaviour at the terminal value, and one-shot stop.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | count holds; act=1 starts a run and steps on the same edge
// RUN   | count steps every cycle in the sampled direction
// DONE  | one-shot terminal reached; count holds until act drops
module updown_mod_counter #(
   parameter int unsigned WIDTH = 5,
   parameter bit          WRAP  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             act,
   input  logic             up_dwn_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   input  logic             one_shot,
   output logic [WIDTH-1:0] count,
   output logic             ovflw,
   output logic             unflw,
   output logic             done,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] count_d;
   logic             ovflw_d;
   logic             unflw_d;
   logic             sat_hit_q;
   logic             sat_hit_d;
   logic             do_step;
   logic             term;
   logic [WIDTH-1:0] term_val;
   logic [WIDTH-1:0] wrap_val;
   logic             pulse;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         count     <= '0;
         ovflw     <= 1'b0;
         unflw     <= 1'b0;
         sat_hit_q <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         count     <= count_d;
         ovflw     <= ovflw_d;
         unflw     <= unflw_d;
         sat_hit_q <= sat_hit_d;
         busy      <= (state_d == RUN);
         done      <= (state_d == DONE);
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count;
      ovflw_d   = 1'b0;
      unflw_d   = 1'b0;
      sat_hit_d = sat_hit_q;
      do_step   = 1'b0;
      pulse     = 1'b0;
      term      = up_dwn_n ? (count >= limit) : (count == '0);
      term_val  = up_dwn_n ? limit : '0;
      wrap_val  = up_dwn_n ? '0 : limit;

      if (load) begin
         count_d   = (load_val > limit) ? limit : load_val;
         sat_hit_d = 1'b0;
         if (state_q == DONE) state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (act) begin
                  state_d = RUN;
                  do_step = 1'b1;
               end
            end
            RUN: begin
               if (act) do_step = 1'b1;
               else     state_d = IDLE;
            end
            DONE: begin
               if (!act) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      if (do_step) begin
         if (!term) begin
            count_d   = up_dwn_n ? (count + ONE) : (count - ONE);
            sat_hit_d = 1'b0;
         end else if (one_shot) begin
            count_d = term_val;
            pulse   = 1'b1;
            state_d = DONE;
         end else if (WRAP) begin
            count_d = wrap_val;
            pulse   = 1'b1;
         end else begin
            // saturated: flag only on the first arrival at the terminal value
            count_d   = term_val;
            pulse     = !sat_hit_q;
            sat_hit_d = 1'b1;
         end
      end

      if (pulse) begin
         ovflw_d = up_dwn_n;
         unflw_d = !up_dwn_n;
      end
   end

endmodule
